// File: rtl/rrd_pkg.sv
// Shared types and helpers for the register-file write-back arbiter.
// The geometry constants are the default register-file shape.
package rrd_pkg;

  localparam int S_INDEX = 5;
  localparam int S_WIDTH = 32;

  typedef struct packed {
    logic [S_INDEX-1:0] dest;
    logic [S_WIDTH-1:0] data;
  } wb_entry_t;

  localparam logic [S_INDEX-1:0] REG_ZERO = '0;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source result FIFO: binary read/write pointers plus an occupancy count.
// Callers must only push when !full and only pop when !empty.
module wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // NOTE: storage has no reset; an entry is only ever read after count says it was written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: buffers execution-unit results per source and issues up to
// num_write_ports non-conflicting register-file writes per cycle, round-robin.
module wb_arbiter import rrd_pkg::*; #(
  parameter int s_index         = S_INDEX,
  parameter int s_width         = S_WIDTH,
  parameter int num_sources     = 4,
  parameter int num_write_ports = 2,
  parameter int fifo_depth      = 2
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [num_sources-1:0]                        src_valid,
  output logic [num_sources-1:0]                        src_ready,
  input  logic [num_sources-1:0][s_index-1:0]           src_dest,
  input  logic [num_sources-1:0][s_width-1:0]           src_data,
  output logic [num_write_ports-1:0]                    ld,
  output logic [num_write_ports-1:0][s_index-1:0]       dest,
  output logic [num_write_ports-1:0][s_width-1:0]       in,
  output logic                                          busy
);

  localparam int NSRC = num_sources;
  localparam int NWP  = num_write_ports;
  localparam int PW   = (NSRC > 1) ? $clog2(NSRC) : 1;

  typedef struct packed {
    logic [s_index-1:0] dest;
    logic [s_width-1:0] data;
  } entry_t;

  entry_t                         head [NSRC];
  logic [NSRC-1:0]                full, empty, push, pop;
  logic [PW-1:0]                  rr_ptr, rr_nxt, idx;
  logic [NWP-1:0]                 ld_nxt;
  logic [NWP-1:0][s_index-1:0]    dest_nxt;
  logic [NWP-1:0][s_width-1:0]    in_nxt;
  logic                           conflict, granted;

  // Readiness comes from registered occupancy only, so no valid-to-ready path exists.
  assign src_ready = ~full;
  assign push      = src_valid & ~full;
  assign busy      = ~(&empty) | (|ld);

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    wb_fifo #(.W($bits(entry_t)), .DEPTH(fifo_depth)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   ({src_dest[g], src_data[g]}),
      .full  (full[g]),
      .empty (empty[g]),
      .head  (head[g])
    );
  end

  // Scan heads from rr_ptr; each grant takes the lowest free port, so port k gets grant k.
  always_comb begin
    // NOTE: every signal gets a default before the scan so no path leaves one unassigned.
    pop      = '0;
    ld_nxt   = '0;
    dest_nxt = dest;
    in_nxt   = in;
    rr_nxt   = rr_ptr;
    idx      = '0;
    conflict = 1'b0;
    granted  = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      idx      = PW'((32'(rr_ptr) + k) % NSRC);
      conflict = 1'b0;
      granted  = 1'b0;
      if (!empty[idx]) begin
        if (head[idx].dest == s_index'(REG_ZERO)) begin
          pop[idx] = 1'b1;
        end else begin
          for (int p = 0; p < NWP; p++) begin
            if (ld_nxt[p] && dest_nxt[p] == head[idx].dest) conflict = 1'b1;
          end
          for (int p = 0; p < NWP; p++) begin
            if (!conflict && !granted && !ld_nxt[p]) begin
              ld_nxt[p]   = 1'b1;
              dest_nxt[p] = head[idx].dest;
              in_nxt[p]   = head[idx].data;
              granted     = 1'b1;
            end
          end
          if (granted) begin
            pop[idx] = 1'b1;
            rr_nxt   = PW'(rr_next(32'(idx), NSRC));
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      ld     <= '0;
      dest   <= '0;
      in     <= '0;
    end else begin
      rr_ptr <= rr_nxt;
      ld     <= ld_nxt;
      dest   <= dest_nxt;
      in     <= in_nxt;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based model of the write-back rules.
`timescale 1ns/1ps
module tb_wb_arbiter;
  import rrd_pkg::*;

  localparam int SI    = S_INDEX;
  localparam int SW    = S_WIDTH;
  localparam int NSRC  = 4;
  localparam int NWP   = 2;
  localparam int DEPTH = 2;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic [NSRC-1:0]           src_valid;
  logic [NSRC-1:0]           src_ready;
  logic [NSRC-1:0][SI-1:0]   src_dest;
  logic [NSRC-1:0][SW-1:0]   src_data;
  logic [NWP-1:0]            ld;
  logic [NWP-1:0][SI-1:0]    dest;
  logic [NWP-1:0][SW-1:0]    wdata;
  logic                      busy;

  wb_arbiter #(
    .s_index(SI), .s_width(SW), .num_sources(NSRC),
    .num_write_ports(NWP), .fifo_depth(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_dest(src_dest), .src_data(src_data),
    .ld(ld), .dest(dest), .in(wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  wb_entry_t               mq [NSRC][$];
  int                      m_rr;
  logic [NWP-1:0]          exp_ld;
  logic [NWP-1:0][SI-1:0]  exp_dest;
  logic [NWP-1:0][SW-1:0]  exp_in;
  logic [SW-1:0]           dut_rf [32];
  logic [SW-1:0]           mdl_rf [32];
  int                      dut_writes;
  int                      acc_nonzero;
  bit                      seen_rdy1_lo, seen_rdy1_hi;
  bit                      collect_src1;
  logic [SW-1:0]           dut_src1 [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_empty();
    for (int i = 0; i < NSRC; i++) if (mq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock of the write-back rules, applied to the inputs currently driven.
  task automatic model_step();
    bit [NSRC-1:0] rdy;
    bit [NSRC-1:0] popm;
    bit            any;
    int            last;
    logic [SI-1:0] used [$];
    for (int i = 0; i < NSRC; i++) rdy[i] = (mq[i].size() < DEPTH);
    popm   = '0;
    any    = 1'b0;
    last   = 0;
    exp_ld = '0;
    for (int k = 0; k < NSRC; k++) begin
      int s;
      bit clash;
      s = (m_rr + k) % NSRC;
      if (mq[s].size() == 0) continue;
      if (mq[s][0].dest == 0) begin
        popm[s] = 1'b1;
        continue;
      end
      if (used.size() == NWP) continue;
      clash = 1'b0;
      foreach (used[u]) if (used[u] == mq[s][0].dest) clash = 1'b1;
      if (clash) continue;
      exp_ld[used.size()]   = 1'b1;
      exp_dest[used.size()] = mq[s][0].dest;
      exp_in[used.size()]   = mq[s][0].data;
      mdl_rf[mq[s][0].dest] = mq[s][0].data;
      used.push_back(mq[s][0].dest);
      popm[s] = 1'b1;
      any     = 1'b1;
      last    = s;
    end
    if (any) m_rr = (last + 1) % NSRC;
    for (int i = 0; i < NSRC; i++) begin
      if (popm[i]) void'(mq[i].pop_front());
      if (src_valid[i] && rdy[i]) begin
        mq[i].push_back('{dest: src_dest[i], data: src_data[i]});
        if (src_dest[i] != 0) acc_nonzero++;
      end
    end
  endtask

  task automatic compare(input string tag);
    bit bz;
    check({tag, ".ld"}, 64'(ld), 64'(exp_ld));
    for (int p = 0; p < NWP; p++) begin
      check($sformatf("%s.dest%0d", tag, p), 64'(dest[p]), 64'(exp_dest[p]));
      check($sformatf("%s.in%0d", tag, p), 64'(wdata[p]), 64'(exp_in[p]));
    end
    for (int i = 0; i < NSRC; i++)
      check($sformatf("%s.ready%0d", tag, i), 64'(src_ready[i]), 64'(mq[i].size() < DEPTH));
    bz = (exp_ld != '0) || !model_empty();
    check({tag, ".busy"}, 64'(busy), 64'(bz));
    if (&ld) check({tag, ".dup_dest"}, 64'(dest[0] == dest[1]), 64'(0));
    for (int p = 0; p < NWP; p++) begin
      if (ld[p] === 1'b1) begin
        dut_rf[dest[p]] = wdata[p];
        dut_writes++;
        if (collect_src1 && dest[p] < 8) dut_src1.push_back(wdata[p]);
      end
    end
    if (src_ready[1] === 1'b1) seen_rdy1_hi = 1'b1;
    else                       seen_rdy1_lo = 1'b1;
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare(tag);
  endtask

  task automatic idle();
    src_valid = '0;
    src_dest  = '0;
    src_data  = '0;
  endtask

  task automatic reset_dut();
    idle();
    rst = 1'b1;
    #1;
    check("rst.ld", 64'(ld), 64'(0));
    check("rst.busy", 64'(busy), 64'(0));
    for (int i = 0; i < NSRC; i++) mq[i].delete();
    m_rr     = 0;
    exp_ld   = '0;
    exp_dest = '0;
    exp_in   = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.ready", 64'(src_ready), 64'({NSRC{1'b1}}));
  endtask

  task automatic drain(input string tag);
    idle();
    for (int n = 0; n < 30; n++) begin
      if (model_empty() && exp_ld == '0) break;
      cycle(tag);
    end
    check({tag, ".idle_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 32; r++) begin
      dut_rf[r] = '0;
      mdl_rf[r] = '0;
    end
    dut_writes   = 0;
    acc_nonzero  = 0;
    collect_src1 = 1'b0;
    idle();
    #2;
    reset_dut();

    // 1: reset mid-stream with three entries queued
    src_valid = 4'b0111;
    src_dest  = {5'd0, 5'd3, 5'd2, 5'd1};
    src_data  = {32'h0, 32'h333, 32'h222, 32'h111};
    cycle("t1a");
    idle();
    cycle("t1b");
    reset_dut();
    for (int n = 0; n < 3; n++) cycle("t1_post");

    // 2: single source, back to back
    src_valid    = 4'b0001;
    src_dest[0]  = 5'd5;
    src_data[0]  = 32'hA5;
    cycle("t2a");
    check("t2a.ld_early", 64'(ld), 64'(0));
    src_dest[0]  = 5'd6;
    src_data[0]  = 32'h5A;
    cycle("t2b");
    check("t2b.ld", 64'(ld), 64'(2'b01));
    check("t2b.dest", 64'(dest[0]), 64'(5));
    check("t2b.in", 64'(wdata[0]), 64'(32'hA5));
    idle();
    cycle("t2c");
    check("t2c.ld", 64'(ld), 64'(2'b01));
    check("t2c.dest", 64'(dest[0]), 64'(6));
    check("t2c.in", 64'(wdata[0]), 64'(32'h5A));
    cycle("t2d");
    check("t2d.ld", 64'(ld), 64'(0));

    // 3: all sources every cycle, distinct dests; grants alternate 0,1 / 2,3
    reset_dut();
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < NSRC; i++) begin
        src_valid[i] = 1'b1;
        src_dest[i]  = SI'(1 + i * 7 + b % 7);
        src_data[i]  = SW'((i << 16) | b);
      end
      cycle("t3");
      if (b >= 1) begin
        check($sformatf("t3.ld_b%0d", b), 64'(ld), 64'(2'b11));
        check($sformatf("t3.port0_src_b%0d", b), 64'(wdata[0][31:16]), 64'((b % 2) ? 0 : 2));
        check($sformatf("t3.port1_src_b%0d", b), 64'(wdata[1][31:16]), 64'((b % 2) ? 1 : 3));
      end
    end
    drain("t3_drain");

    // 4: same-dest conflict between src0 and src1
    reset_dut();
    src_valid   = 4'b0011;
    src_dest[0] = 5'd7;
    src_data[0] = 32'h11;
    src_dest[1] = 5'd7;
    src_data[1] = 32'h22;
    cycle("t4a");
    idle();
    cycle("t4b");
    check("t4b.ld", 64'(ld), 64'(2'b01));
    check("t4b.in", 64'(wdata[0]), 64'(32'h11));
    cycle("t4c");
    check("t4c.ld", 64'(ld), 64'(2'b01));
    check("t4c.in", 64'(wdata[0]), 64'(32'h22));
    cycle("t4d");
    check("t4d.ld", 64'(ld), 64'(0));

    // 5: zero destination is dropped without a write
    reset_dut();
    src_valid   = 4'b0100;
    src_dest[2] = 5'd0;
    src_data[2] = 32'hDEAD;
    cycle("t5a");
    src_dest[2] = 5'd3;
    src_data[2] = 32'h33;
    cycle("t5b");
    check("t5b.ld", 64'(ld), 64'(0));
    idle();
    cycle("t5c");
    check("t5c.ld", 64'(ld), 64'(2'b01));
    check("t5c.dest", 64'(dest[0]), 64'(3));
    check("t5c.in", 64'(wdata[0]), 64'(32'h33));

    // 6: backpressure on src1 while the others saturate, then random traffic
    reset_dut();
    acc_nonzero  = 0;
    dut_writes   = 0;
    seen_rdy1_lo = 1'b0;
    seen_rdy1_hi = 1'b0;
    collect_src1 = 1'b1;
    begin
      int b1;
      b1 = 0;
      for (int n = 0; n < 60 && b1 < DEPTH + 3; n++) begin
        bit acc;
        for (int i = 0; i < NSRC; i++) begin
          src_valid[i] = 1'b1;
          src_dest[i]  = SI'($urandom_range(8, 31));
          src_data[i]  = $urandom;
        end
        src_dest[1] = SI'(1 + b1);
        src_data[1] = SW'(32'h1000_0000 | b1);
        acc = (mq[1].size() < DEPTH);
        cycle("t6_bp");
        if (acc) b1++;
      end
      check("t6.beats_sent", 64'(b1), 64'(DEPTH + 3));
    end
    drain("t6_bp_drain");
    collect_src1 = 1'b0;
    check("t6.ready_toggle", 64'({seen_rdy1_lo, seen_rdy1_hi}), 64'(2'b11));
    check("t6.src1_count", 64'(dut_src1.size()), 64'(DEPTH + 3));
    foreach (dut_src1[k])
      check($sformatf("t6.src1_order%0d", k), 64'(dut_src1[k]), 64'(32'h1000_0000 | k));

    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NSRC; i++) begin
        src_valid[i] = 1'($urandom_range(0, 1));
        src_dest[i]  = SI'($urandom_range(0, 31));
        src_data[i]  = $urandom;
      end
      cycle("t6_rand");
    end
    drain("t6_rand_drain");
    check("t6.write_count", 64'(dut_writes), 64'(acc_nonzero));
    for (int r = 0; r < 32; r++)
      check($sformatf("t6.rf%0d", r), 64'(dut_rf[r]), 64'(mdl_rf[r]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
